// File: rtl/fft_pkg.sv
// Shared definitions for the FFT read-out path: FSM state encodings,
// default widths and the bit-reversal helper.
package fft_pkg;

    localparam int DEF_BITNESS = 16;
    localparam int DEF_ADDR_W  = 8;
    localparam int MAX_ADDR_W  = 16;
    localparam int IDX_W       = $clog2(MAX_ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] v,
                                                     input int w);
        logic [MAX_ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            if (i < w) begin
                r[IDX_W'(i)] = v[IDX_W'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_fifo2.sv
// Two-entry FIFO between the memory read port and the output handshake.
// Head entry is presented combinationally from registers, so it holds steady while stalled.
module fft_out_fifo2
    import fft_pkg::*;
#(
    parameter int W = 2 * DEF_BITNESS + 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_wr,
    input  logic [W-1:0] i_din,
    input  logic         i_rd,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_wr_ok;
    logic         w_rd_ok;

    assign w_rd_ok = i_rd && (r_count != 2'd0);
    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_wr_ok = i_wr && ((r_count != 2'd2) || w_rd_ok);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_rd_ok) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_wr_ok) - 2'(w_rd_ok);
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/fft_out_reader.sv
// Streams an FFT frame out of working memory over valid/ready.
// Define FFT_OUT_BITREV_EN to read in bit-reversed address order; otherwise memory order.
module fft_out_reader
    import fft_pkg::*;
#(
    parameter int BITNESS = DEF_BITNESS,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_START,
    output logic                 o_BUSY,
    output logic                 o_RD_EN,
    output logic [ADDR_W-1:0]    o_RD_ADDR,
    input  logic [2*BITNESS-1:0] i_RD_DATA,
    output logic [2*BITNESS-1:0] o_DATA,
    output logic                 o_VALID,
    input  logic                 i_READY,
    output logic                 o_LAST,
    output logic                 o_DONE
);

    localparam int DW = 2 * BITNESS + 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_pend;
    logic              r_pend_last;
    logic              r_busy;
    logic              r_done;

    logic [1:0]        w_count;
    logic [2:0]        w_room;
    logic              w_valid;
    logic              w_pop;
    logic              w_issue;
    logic              w_last_rd;
    logic [DW-1:0]     w_head;

    assign w_pop     = w_valid & i_READY;
    assign w_last_rd = (r_cnt == '1);

    // Entries that will still be held after this edge; the pop this cycle frees a slot,
    // which is what lets one read per cycle sustain with only two entries.
    assign w_room  = ({1'b0, w_count} + 3'(r_pend)) - 3'(w_pop);
    assign w_issue = (r_state == ST_READ) && (w_room < 3'd2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_pend      <= w_issue;
            r_pend_last <= w_issue & w_last_rd;
            if (w_issue) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_START) begin
                        r_state <= ST_READ;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_issue && w_last_rd) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_head[DW-1]) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FFT_OUT_BITREV_EN
    assign o_RD_ADDR = ADDR_W'(bitrev(MAX_ADDR_W'(r_cnt), ADDR_W));
`else
    assign o_RD_ADDR = r_cnt;
`endif

    fft_out_fifo2 #(
        .W(DW)
    ) u_fifo (
        .clk     (CLK),
        .srst    (RST),
        .i_wr    (r_pend),
        .i_din   ({r_pend_last, i_RD_DATA}),
        .i_rd    (w_pop),
        .o_dout  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign o_RD_EN = w_issue;
    assign o_BUSY  = r_busy;
    assign o_DONE  = r_done;
    assign o_VALID = w_valid;
    assign o_DATA  = w_head[DW-2:0];
    assign o_LAST  = w_valid & w_head[DW-1];

endmodule

// File: tb/tb_fft_out_reader.sv
// Directed bench for fft_out_reader with N=8 and mem[a] = {re=a, im=8+a}.
module tb_fft_out_reader;

    localparam int BW = 16;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_START = 1'b0;
    logic          i_READY = 1'b0;
    logic [2*BW-1:0] i_RD_DATA;
    logic          o_BUSY, o_RD_EN, o_VALID, o_LAST, o_DONE;
    logic [AW-1:0] o_RD_ADDR;
    logic [2*BW-1:0] o_DATA;

    fft_out_reader #(.BITNESS(BW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .i_START(i_START), .o_BUSY(o_BUSY),
        .o_RD_EN(o_RD_EN), .o_RD_ADDR(o_RD_ADDR), .i_RD_DATA(i_RD_DATA),
        .o_DATA(o_DATA), .o_VALID(o_VALID), .i_READY(i_READY),
        .o_LAST(o_LAST), .o_DONE(o_DONE)
    );

    always #5 CLK = ~CLK;

    // Memory with one cycle of read latency.
    always @(posedge CLK) begin
        if (RST) i_RD_DATA <= 32'hdead_beef;
        else if (o_RD_EN) i_RD_DATA <= {16'(o_RD_ADDR), 16'(o_RD_ADDR) + 16'd8};
    end

    int n_checks = 0;
    int n_pass = 0;

    // Handshake recorder and protocol watchers.
    int n_hs = 0, n_rd = 0, n_done = 0, stall_viol = 0, occ_viol = 0, outst = 0;
    logic [15:0] got_re [256];
    logic [15:0] got_im [256];
    logic        got_last [256];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
            outst = 0;
        end else begin
            if (prev_stall && (o_DATA !== prev_data || o_LAST !== prev_last)) stall_viol++;
            if (o_RD_EN) begin
                if (outst - ((o_VALID && i_READY) ? 1 : 0) >= 2) occ_viol++;
                n_rd++;
                outst++;
            end
            if (o_VALID && i_READY && n_hs < 256) begin
                got_re[n_hs] = o_DATA[31:16];
                got_im[n_hs] = o_DATA[15:0];
                got_last[n_hs] = o_LAST;
                $display("hs %0d: re=%0d im=%0d last=%0b", n_hs, o_DATA[31:16], o_DATA[15:0], o_LAST);
                n_hs++;
                outst--;
            end
            if (o_DONE) n_done++;
            prev_stall = o_VALID && !i_READY;
            prev_data = o_DATA;
            prev_last = o_LAST;
        end
    end

    int exp_br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int exp_re(input int i);
`ifdef FFT_OUT_BITREV_EN
        return exp_br[i];
`else
        return i;
`endif
    endfunction

    function automatic logic ready_for(input int mode, input int i);
        if (mode == 1) return (i % 4 == 0) || (i % 4 == 3);
        if (mode == 2) return i >= 20;
        return 1'b1;
    endfunction

    // Per-cycle trace of the last frame, indexed by cycles after i_START.
    logic        tr_valid [200];
    logic        tr_rden  [200];
    logic        tr_busy  [200];
    logic [AW-1:0] tr_addr [200];
    logic [15:0] tr_re    [200];
    int          rd_cum   [200];

    task automatic run_frame(input int mode, input bit extra, output int done_at);
        int rd_seen;
        done_at = -1;
        rd_seen = 0;
        @(posedge CLK); #1;
        i_START = 1'b1;
        i_READY = ready_for(mode, 0);
        for (int i = 1; i < 200; i++) begin
            @(posedge CLK); #1;
            i_START = extra && (i == 4);
            i_READY = ready_for(mode, i);
            @(negedge CLK);
            if (o_RD_EN) rd_seen++;
            tr_valid[i] = o_VALID; tr_rden[i] = o_RD_EN; tr_busy[i] = o_BUSY;
            tr_addr[i] = o_RD_ADDR; tr_re[i] = o_DATA[31:16]; rd_cum[i] = rd_seen;
            if (o_DONE) begin
                done_at = i;
                break;
            end
        end
        i_START = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        n_checks++; if (o_BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_BUSY); else n_pass++;
        n_checks++; if (o_RD_EN !== 1'b0) $display("FAIL reset_rden: got %b expected 0", o_RD_EN); else n_pass++;
        n_checks++; if (o_RD_ADDR !== 3'd0) $display("FAIL reset_addr: got %0d expected 0", o_RD_ADDR); else n_pass++;
        n_checks++; if (o_DATA !== 32'd0) $display("FAIL reset_data: got %h expected 0", o_DATA); else n_pass++;
        n_checks++; if (o_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_VALID); else n_pass++;
        n_checks++; if (o_LAST !== 1'b0) $display("FAIL reset_last: got %b expected 0", o_LAST); else n_pass++;
        n_checks++; if (o_DONE !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_DONE); else n_pass++;
    endtask

    task automatic test_stream();
        int b_hs, b_done, d;
        b_hs = n_hs; b_done = n_done;
        run_frame(0, 1'b0, d);
        n_checks++; if (tr_busy[1] !== 1'b1) $display("FAIL stream_busy1: got %b expected 1", tr_busy[1]); else n_pass++;
        n_checks++; if (tr_rden[1] !== 1'b1) $display("FAIL stream_rden1: got %b expected 1", tr_rden[1]); else n_pass++;
        n_checks++; if (tr_addr[1] !== 3'd0) $display("FAIL stream_addr1: got %0d expected 0", tr_addr[1]); else n_pass++;
        n_checks++; if (tr_addr[2] !== 3'(exp_re(1))) $display("FAIL stream_addr2: got %0d expected %0d", tr_addr[2], exp_re(1)); else n_pass++;
        n_checks++; if (tr_valid[2] !== 1'b0) $display("FAIL stream_valid2: got %b expected 0", tr_valid[2]); else n_pass++;
        n_checks++; if (tr_valid[3] !== 1'b1) $display("FAIL stream_valid3: got %b expected 1", tr_valid[3]); else n_pass++;
        n_checks++; if (d != 11) $display("FAIL stream_done_cycle: got %0d expected 11", d); else n_pass++;
        n_checks++; if (d > 0 && tr_busy[d] !== 1'b0) $display("FAIL stream_busy_at_done: got %b expected 0", tr_busy[d]); else n_pass++;
        n_checks++; if (n_hs - b_hs != 8) $display("FAIL stream_count: got %0d expected 8", n_hs - b_hs); else n_pass++;
        n_checks++; if (n_done - b_done != 1) $display("FAIL stream_done_count: got %0d expected 1", n_done - b_done); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_checks++; if (got_re[b_hs+j] !== 16'(exp_re(j))) $display("FAIL stream_re[%0d]: got %0d expected %0d", j, got_re[b_hs+j], exp_re(j)); else n_pass++;
            n_checks++; if (got_im[b_hs+j] !== 16'(exp_re(j) + 8)) $display("FAIL stream_im[%0d]: got %0d expected %0d", j, got_im[b_hs+j], exp_re(j) + 8); else n_pass++;
            n_checks++; if (got_last[b_hs+j] !== (j == 7)) $display("FAIL stream_last[%0d]: got %b expected %b", j, got_last[b_hs+j], j == 7); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int b_hs, b_done, b_stall, b_occ, d;
        b_hs = n_hs; b_done = n_done; b_stall = stall_viol; b_occ = occ_viol;
        run_frame(1, 1'b0, d);
        n_checks++; if (d < 0) $display("FAIL bp_timeout: got no done expected done"); else n_pass++;
        n_checks++; if (n_hs - b_hs != 8) $display("FAIL bp_count: got %0d expected 8", n_hs - b_hs); else n_pass++;
        n_checks++; if (n_done - b_done != 1) $display("FAIL bp_done_count: got %0d expected 1", n_done - b_done); else n_pass++;
        n_checks++; if (stall_viol != b_stall) $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_viol - b_stall); else n_pass++;
        n_checks++; if (occ_viol != b_occ) $display("FAIL bp_occupancy: got %0d overreads expected 0", occ_viol - b_occ); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_checks++; if (got_re[b_hs+j] !== 16'(exp_re(j))) $display("FAIL bp_re[%0d]: got %0d expected %0d", j, got_re[b_hs+j], exp_re(j)); else n_pass++;
            n_checks++; if (got_last[b_hs+j] !== (j == 7)) $display("FAIL bp_last[%0d]: got %b expected %b", j, got_last[b_hs+j], j == 7); else n_pass++;
        end
    endtask

    task automatic test_restart_ignored();
        int b_hs, b_done, b_rd, d;
        b_hs = n_hs; b_done = n_done;
        run_frame(0, 1'b1, d);
        n_checks++; if (d != 11) $display("FAIL restart_done_cycle: got %0d expected 11", d); else n_pass++;
        n_checks++; if (n_hs - b_hs != 8) $display("FAIL restart_count: got %0d expected 8", n_hs - b_hs); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_checks++; if (got_re[b_hs+j] !== 16'(exp_re(j))) $display("FAIL restart_re[%0d]: got %0d expected %0d", j, got_re[b_hs+j], exp_re(j)); else n_pass++;
        end
        b_rd = n_rd;
        repeat (6) @(negedge CLK);
        #1;
        n_checks++; if (n_done - b_done != 1) $display("FAIL restart_done_count: got %0d expected 1", n_done - b_done); else n_pass++;
        n_checks++; if (n_rd != b_rd) $display("FAIL restart_extra_reads: got %0d expected 0", n_rd - b_rd); else n_pass++;
        n_checks++; if (o_BUSY !== 1'b0) $display("FAIL restart_busy_after: got %b expected 0", o_BUSY); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int b_hs, b_done, d;
        bit seen;
        b_hs = n_hs; b_done = n_done; seen = 1'b0;
        @(posedge CLK); #1 i_START = 1'b1; i_READY = 1'b1;
        @(posedge CLK); #1 i_START = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK); #1;
            if (n_hs - b_hs >= 3) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL rstmid_third_hs: got %0d expected 3", n_hs - b_hs); else n_pass++;
        @(posedge CLK); #1 RST = 1'b1; i_READY = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        n_checks++; if (o_BUSY !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", o_BUSY); else n_pass++;
        n_checks++; if (o_RD_EN !== 1'b0) $display("FAIL rstmid_rden: got %b expected 0", o_RD_EN); else n_pass++;
        n_checks++; if (o_VALID !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", o_VALID); else n_pass++;
        n_checks++; if (o_DATA !== 32'd0) $display("FAIL rstmid_data: got %h expected 0", o_DATA); else n_pass++;
        n_checks++; if (o_RD_ADDR !== 3'd0) $display("FAIL rstmid_addr: got %0d expected 0", o_RD_ADDR); else n_pass++;
        n_checks++; if (o_LAST !== 1'b0 || o_DONE !== 1'b0) $display("FAIL rstmid_last_done: got %b%b expected 00", o_LAST, o_DONE); else n_pass++;
        #1;
        n_checks++; if (n_done != b_done) $display("FAIL rstmid_no_done: got %0d expected 0", n_done - b_done); else n_pass++;
        b_hs = n_hs;
        run_frame(0, 1'b0, d);
        n_checks++; if (d != 11) $display("FAIL rstmid_new_done: got %0d expected 11", d); else n_pass++;
        n_checks++; if (n_hs - b_hs != 8) $display("FAIL rstmid_new_count: got %0d expected 8", n_hs - b_hs); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_checks++; if (got_re[b_hs+j] !== 16'(exp_re(j))) $display("FAIL rstmid_re[%0d]: got %0d expected %0d", j, got_re[b_hs+j], exp_re(j)); else n_pass++;
        end
    endtask

    task automatic test_long_stall();
        int b_hs, d;
        b_hs = n_hs;
        run_frame(2, 1'b0, d);
        n_checks++; if (rd_cum[19] != 2) $display("FAIL stall_reads: got %0d expected 2", rd_cum[19]); else n_pass++;
        n_checks++; if (tr_valid[19] !== 1'b1) $display("FAIL stall_valid: got %b expected 1", tr_valid[19]); else n_pass++;
        n_checks++; if (tr_re[19] !== 16'd0) $display("FAIL stall_head_re: got %0d expected 0", tr_re[19]); else n_pass++;
        n_checks++; if (d < 0) $display("FAIL stall_timeout: got no done expected done"); else n_pass++;
        n_checks++; if (n_hs - b_hs != 8) $display("FAIL stall_count: got %0d expected 8", n_hs - b_hs); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_checks++; if (got_re[b_hs+j] !== 16'(exp_re(j))) $display("FAIL stall_re[%0d]: got %0d expected %0d", j, got_re[b_hs+j], exp_re(j)); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_long_stall();
        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
